// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared types and constants for the row normalization block
package norm_pkg;

  // Sequencer states: read/accumulate, cross-core sync, re-read/divide, write back
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_RD = 3'd1,
    ACC    = 3'd2,
    SYNC   = 3'd3,
    DIV_RD = 3'd4,
    DIV    = 3'd5,
    WB     = 3'd6,
    DONE   = 3'd7
  } norm_state_e;

  // Datapath widths shared with the norm datapath
  localparam int SUM_W  = 20;
  localparam int PSUM_W = 16;

  // States in which the psum memory is read
  function automatic logic is_rd_state(input norm_state_e s);
    return (s == ACC_RD) || (s == DIV_RD);
  endfunction

endpackage

// File: rtl/norm_ctrl.sv
// rtl/norm_ctrl.sv - per-row normalization sequencer with cross-core sum sync
module norm_ctrl
  import norm_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              solo,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              pmem_rd,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              norm_acc,
  output logic              norm_div,
  output logic              omem_wr,
  output logic [ADDR_W-1:0] omem_addr,
  output logic              sync_out,
  input  logic              sync_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  row
);

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  norm_state_e       state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;

  logic              pmem_rd_q, pmem_rd_d;
  logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
  logic              norm_acc_q, norm_acc_d;
  logic              norm_div_q, norm_div_d;
  logic              omem_wr_q, omem_wr_d;
  logic [ADDR_W-1:0] omem_addr_q, omem_addr_d;
  logic              sync_out_q, sync_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next state, row counter and base latching; start only counts in IDLE
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_base_d = rd_base;
          wr_base_d = wr_base;
          row_d     = '0;
          state_d   = ACC_RD;
        end
      end
      ACC_RD: state_d = ACC;
      ACC:    state_d = SYNC;
      SYNC: begin
        if (sync_in || solo) begin
          state_d = DIV_RD;
        end
      end
      DIV_RD: state_d = DIV;
      DIV:    state_d = WB;
      WB: begin
        if (row_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ACC_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they line up with the state once registered
  always_comb begin
    pmem_rd_d   = is_rd_state(state_d);
    pmem_addr_d = pmem_rd_d ? rd_base_d + ADDR_W'(row_d) : '0;
    norm_acc_d  = (state_d == ACC);
    norm_div_d  = (state_d == DIV);
    omem_wr_d   = (state_d == WB);
    omem_addr_d = omem_wr_d ? wr_base_d + ADDR_W'(row_d) : '0;
    sync_out_d  = (state_d == SYNC);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, counter, bases and registered outputs; reset aborts a pass silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      pmem_rd_q   <= 1'b0;
      pmem_addr_q <= '0;
      norm_acc_q  <= 1'b0;
      norm_div_q  <= 1'b0;
      omem_wr_q   <= 1'b0;
      omem_addr_q <= '0;
      sync_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      pmem_rd_q   <= pmem_rd_d;
      pmem_addr_q <= pmem_addr_d;
      norm_acc_q  <= norm_acc_d;
      norm_div_q  <= norm_div_d;
      omem_wr_q   <= omem_wr_d;
      omem_addr_q <= omem_addr_d;
      sync_out_q  <= sync_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pmem_rd   = pmem_rd_q;
  assign pmem_addr = pmem_addr_q;
  assign norm_acc  = norm_acc_q;
  assign norm_div  = norm_div_q;
  assign omem_wr   = omem_wr_q;
  assign omem_addr = omem_addr_q;
  assign sync_out  = sync_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign row       = row_q;

endmodule

// File: tb/tb_norm_ctrl.sv
// tb/tb_norm_ctrl.sv - self-checking bench for norm_ctrl
module tb_norm_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] exp_rd[$];
  logic [3:0] exp_wr[$];

  // instance A (ROWS=8), instance B (ROWS=8, cross-coupling partner), instance C (ROWS=1)
  logic       a_start, a_solo, a_sync_in, tb_sync_in, xmode;
  logic [3:0] a_rd_base, a_wr_base;
  logic       a_pmem_rd, a_norm_acc, a_norm_div, a_omem_wr, a_sync_out, a_busy, a_done;
  logic [3:0] a_pmem_addr, a_omem_addr, a_row;

  logic       b_start;
  logic       b_pmem_rd, b_norm_acc, b_norm_div, b_omem_wr, b_sync_out, b_busy, b_done;
  logic [3:0] b_pmem_addr, b_omem_addr, b_row;

  logic       c_start;
  logic [3:0] c_rd_base, c_wr_base;
  logic       c_pmem_rd, c_norm_acc, c_norm_div, c_omem_wr, c_sync_out, c_busy, c_done;
  logic [3:0] c_pmem_addr, c_omem_addr, c_row;

  assign a_sync_in = xmode ? b_sync_out : tb_sync_in;

  norm_ctrl #(.ROWS(8), .ADDR_W(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .solo(a_solo),
    .rd_base(a_rd_base), .wr_base(a_wr_base),
    .pmem_rd(a_pmem_rd), .pmem_addr(a_pmem_addr), .norm_acc(a_norm_acc), .norm_div(a_norm_div),
    .omem_wr(a_omem_wr), .omem_addr(a_omem_addr), .sync_out(a_sync_out), .sync_in(a_sync_in),
    .busy(a_busy), .done(a_done), .row(a_row)
  );

  norm_ctrl #(.ROWS(8), .ADDR_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .solo(1'b0),
    .rd_base(4'd0), .wr_base(4'd8),
    .pmem_rd(b_pmem_rd), .pmem_addr(b_pmem_addr), .norm_acc(b_norm_acc), .norm_div(b_norm_div),
    .omem_wr(b_omem_wr), .omem_addr(b_omem_addr), .sync_out(b_sync_out), .sync_in(a_sync_out),
    .busy(b_busy), .done(b_done), .row(b_row)
  );

  norm_ctrl #(.ROWS(1), .ADDR_W(4), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .solo(1'b1),
    .rd_base(c_rd_base), .wr_base(c_wr_base),
    .pmem_rd(c_pmem_rd), .pmem_addr(c_pmem_addr), .norm_acc(c_norm_acc), .norm_div(c_norm_div),
    .omem_wr(c_omem_wr), .omem_addr(c_omem_addr), .sync_out(c_sync_out), .sync_in(1'b0),
    .busy(c_busy), .done(c_done), .row(c_row)
  );

  // monitor view of the instance under test (0 = A, 1 = C)
  int         sel;
  logic       m_pmem_rd, m_norm_acc, m_norm_div, m_omem_wr, m_sync_out, m_busy, m_done;
  logic [3:0] m_pmem_addr, m_omem_addr, m_row;

  always_comb begin
    if (sel == 1) begin
      m_pmem_rd = c_pmem_rd; m_pmem_addr = c_pmem_addr; m_norm_acc = c_norm_acc;
      m_norm_div = c_norm_div; m_omem_wr = c_omem_wr; m_omem_addr = c_omem_addr;
      m_sync_out = c_sync_out; m_busy = c_busy; m_done = c_done; m_row = c_row;
    end else begin
      m_pmem_rd = a_pmem_rd; m_pmem_addr = a_pmem_addr; m_norm_acc = a_norm_acc;
      m_norm_div = a_norm_div; m_omem_wr = a_omem_wr; m_omem_addr = a_omem_addr;
      m_sync_out = a_sync_out; m_busy = a_busy; m_done = a_done; m_row = a_row;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) c_start = v;
    else a_start = v;
  endtask

  // Full pass on the selected instance; expectations queued up front, popped as strobes appear
  task automatic run_pass(input string tag, input int s, input logic [3:0] rb, input logic [3:0] wb,
                          input logic sl, input int dly, input int nrows, input bit start_busy);
    int exp_done, done_at, n_acc, n_div, n_done, cnt, bad_onehot, bad_sync;
    bit prev_both;
    logic [3:0] a, got;
    exp_done = nrows * (sl ? 6 : 6 + dly) + 1;
    for (int r = 0; r < nrows; r++) begin
      a = rb + 4'(r);
      exp_rd.push_back(a);
      exp_rd.push_back(a);
      a = wb + 4'(r);
      exp_wr.push_back(a);
    end
    sel = s;
    a_solo = sl;
    if (s == 1) begin c_rd_base = rb; c_wr_base = wb; end
    else begin a_rd_base = rb; a_wr_base = wb; end
    tb_sync_in = 1'b0;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    if (s == 0) begin a_rd_base = ~rb; a_wr_base = ~wb; end
    done_at = -1; n_acc = 0; n_div = 0; n_done = 0; cnt = 0;
    bad_onehot = 0; bad_sync = 0; prev_both = 0;
    for (int k = 1; k <= exp_done + 3; k++) begin
      set_start(s, start_busy && (k == 10));
      if (32'(m_pmem_rd) + 32'(m_norm_acc) + 32'(m_norm_div) + 32'(m_omem_wr) > 1) bad_onehot++;
      if (prev_both && (m_pmem_rd !== 1'b1 || m_sync_out !== 1'b0)) bad_sync++;
      if (m_pmem_rd) begin
        tests_run++;
        if (exp_rd.size() == 0) begin
          tests_failed++;
          $display("FAIL %s rd_extra: cycle %0d addr %0d, expected no read", tag, k, m_pmem_addr);
        end else begin
          got = exp_rd.pop_front();
          if (m_pmem_addr !== got) begin
            tests_failed++;
            $display("FAIL %s pmem_addr: cycle %0d got %0d expected %0d", tag, k, m_pmem_addr, got);
          end
        end
      end
      if (m_omem_wr) begin
        tests_run++;
        if (exp_wr.size() == 0) begin
          tests_failed++;
          $display("FAIL %s wr_extra: cycle %0d addr %0d, expected no write", tag, k, m_omem_addr);
        end else begin
          got = exp_wr.pop_front();
          if (m_omem_addr !== got) begin
            tests_failed++;
            $display("FAIL %s omem_addr: cycle %0d got %0d expected %0d", tag, k, m_omem_addr, got);
          end
        end
      end
      if (m_norm_acc) n_acc++;
      if (m_norm_div) n_div++;
      if (m_done) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (k == exp_done + 1) begin
        tests_run++;
        if (m_busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s busy_after_done: got %0b expected 0", tag, m_busy);
        end
      end
      if (m_sync_out) cnt++;
      else cnt = 0;
      tb_sync_in = !sl && m_sync_out && (cnt >= dly + 1);
      prev_both = m_sync_out && tb_sync_in;
      tick();
    end
    tb_sync_in = 1'b0;
    tests_run++;
    if (done_at != exp_done) begin
      tests_failed++;
      $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_at, exp_done);
    end
    tests_run++;
    if (n_done != 1) begin
      tests_failed++;
      $display("FAIL %s done_count: got %0d expected 1", tag, n_done);
    end
    tests_run++;
    if (n_acc != nrows || n_div != nrows) begin
      tests_failed++;
      $display("FAIL %s strobe_count: acc %0d div %0d expected %0d", tag, n_acc, n_div, nrows);
    end
    tests_run++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      tests_failed++;
      $display("FAIL %s missing_ops: reads left %0d writes left %0d expected 0", tag, exp_rd.size(), exp_wr.size());
    end
    tests_run++;
    if (bad_onehot != 0) begin
      tests_failed++;
      $display("FAIL %s onehot: %0d cycles with several strobes, expected 0", tag, bad_onehot);
    end
    tests_run++;
    if (bad_sync != 0) begin
      tests_failed++;
      $display("FAIL %s sync_exit: %0d late DIV_RD cycles, expected 0", tag, bad_sync);
    end
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if ({a_pmem_rd, a_pmem_addr, a_norm_acc, a_norm_div, a_omem_wr, a_omem_addr,
         a_sync_out, a_busy, a_done, a_row} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a: outputs nonzero, busy %0b row %0d addr %0d", a_busy, a_row, a_pmem_addr);
    end
    tests_run++;
    if ({c_pmem_rd, c_omem_wr, c_busy, c_done, c_row, b_busy, b_done, b_sync_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bc: outputs nonzero, c_busy %0b b_busy %0b expected 0", c_busy, b_busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_solo_pass();
    run_pass("solo", 0, 4'd0, 4'd8, 1'b1, 0, 8, 1'b0);
  endtask

  task automatic test_sync_delay();
    run_pass("sync5", 0, 4'd2, 4'd4, 1'b0, 5, 8, 1'b0);
    run_pass("sync0", 0, 4'd0, 4'd0, 1'b0, 0, 8, 1'b0);
  endtask

  task automatic test_start_busy();
    run_pass("busy_start", 0, 4'd3, 4'd9, 1'b1, 0, 8, 1'b1);
  endtask

  task automatic test_reset_mid_pass();
    int k, n_done;
    sel = 0; a_solo = 1'b1; a_rd_base = 4'd0; a_wr_base = 4'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    k = 0;
    while (!(a_row == 4'd3 && a_norm_div) && k < 100) begin
      tick();
      k++;
    end
    tests_run++;
    if (k >= 100) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: row 3 DIV not seen in %0d cycles", k);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({a_pmem_rd, a_pmem_addr, a_norm_acc, a_norm_div, a_omem_wr, a_omem_addr,
         a_sync_out, a_busy, a_done, a_row} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: busy %0b row %0d div %0b expected all 0", a_busy, a_row, a_norm_div);
    end
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_done || a_busy) n_done++;
    end
    tests_run++;
    if (n_done != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_idle: %0d cycles busy/done after reset, expected 0", n_done);
    end
    run_pass("after_reset", 0, 4'd5, 4'd1, 1'b1, 0, 8, 1'b0);
  endtask

  task automatic test_cross_coupled();
    int a_done_at, b_done_at, lock_bad;
    xmode = 1'b1; a_solo = 1'b0; a_rd_base = 4'd0; a_wr_base = 4'd8;
    a_done_at = -1; b_done_at = -1; lock_bad = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      b_start = (k == 3);
      if (k == 6) begin
        tests_run++;
        if (a_sync_out !== 1'b1 || b_sync_out !== 1'b1) begin
          tests_failed++;
          $display("FAIL xsync_meet: a %0b b %0b expected both 1", a_sync_out, b_sync_out);
        end
      end
      if (k == 7) begin
        tests_run++;
        if (a_pmem_rd !== 1'b1 || b_pmem_rd !== 1'b1) begin
          tests_failed++;
          $display("FAIL xsync_leave: a_rd %0b b_rd %0b expected both 1", a_pmem_rd, b_pmem_rd);
        end
      end
      if (k >= 7 && {a_pmem_rd, a_norm_acc, a_norm_div, a_omem_wr, a_sync_out, a_row} !==
                    {b_pmem_rd, b_norm_acc, b_norm_div, b_omem_wr, b_sync_out, b_row}) lock_bad++;
      if (a_done && a_done_at < 0) a_done_at = k;
      if (b_done && b_done_at < 0) b_done_at = k;
      tick();
    end
    b_start = 1'b0;
    xmode = 1'b0;
    tests_run++;
    if (a_done_at != 52 || b_done_at != 52) begin
      tests_failed++;
      $display("FAIL xdone: a %0d b %0d expected 52 and 52", a_done_at, b_done_at);
    end
    tests_run++;
    if (lock_bad != 0) begin
      tests_failed++;
      $display("FAIL xlockstep: %0d divergent cycles, expected 0", lock_bad);
    end
  endtask

  task automatic test_wrap();
    run_pass("rows1_wrap", 1, 4'd15, 4'd15, 1'b1, 0, 1, 1'b0);
    run_pass("rows8_wrap", 0, 4'd12, 4'd10, 1'b1, 0, 8, 1'b0);
  endtask

  initial begin
    reset = 1'b1; a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_solo = 1'b1; tb_sync_in = 1'b0; xmode = 1'b0; sel = 0;
    a_rd_base = '0; a_wr_base = '0; c_rd_base = '0; c_wr_base = '0;
    test_reset();
    test_solo_pass();
    test_sync_delay();
    test_start_busy();
    test_reset_mid_pass();
    test_cross_coupled();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
